// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the R-type funct codes ALU_Control decodes into md requests.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_SIGN = 2'b10
    } md_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_datapath_step.sv
// One iteration of the unsigned core: shift-add for multiply, restoring
// subtract for divide. Accumulator is {upper, lower} of 2*DATA_WIDTH bits.
module md_datapath_step
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  md_op_e                    i_op,
    input  logic [2*DATA_WIDTH-1:0]   i_acc,
    input  logic [DATA_WIDTH-1:0]     i_opnd,
    output logic [2*DATA_WIDTH-1:0]   o_acc
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W:0] w_sum;
    logic [W:0] w_top;
    logic [W:0] w_diff;

    always_comb begin
        // Multiply: lower half holds the unconsumed multiplier bits.
        w_sum  = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        // Divide: partial remainder after shifting in the next dividend bit.
        w_top  = i_acc[2*W-1:W-1];
        w_diff = w_top - {1'b0, i_opnd};
        o_acc  = '0;
        if (md_is_div(i_op)) begin
            if (!w_diff[W]) begin
                o_acc = {w_diff[W-1:0], i_acc[W-2:0], 1'b1};
            end else begin
                o_acc = {w_top[W-1:0], i_acc[W-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[W-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO for the MIPS core. Works on operand
// magnitudes for DATA_WIDTH cycles, then applies sign fix-up and writes HI/LO.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  mthi_i,
    input  logic                  mtlo_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  div_zero_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    md_state_e        r_state;
    md_op_e           r_op;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_opnd;
    logic [CW-1:0]    r_count;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    md_op_e           w_op_in;
    logic             w_is_div;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic [2*W-1:0]   w_acc_next;
    logic [2*W-1:0]   w_prod;
    logic [W-1:0]     w_quo;
    logic [W-1:0]     w_rem;
    logic             w_div_zero;
    logic [W-1:0]     w_hi_res;
    logic [W-1:0]     w_lo_res;

    always_comb begin
        w_op_in  = md_op_e'(op_i);
        w_is_div = md_is_div(w_op_in);
        w_signed = (w_op_in == MD_MULT) || (w_op_in == MD_DIV);
        w_a_neg  = w_signed & a_i[W-1];
        w_b_neg  = w_signed & b_i[W-1];
        w_a_mag  = w_a_neg ? -a_i : a_i;
        w_b_mag  = w_b_neg ? -b_i : b_i;
    end

    md_datapath_step #(
        .DATA_WIDTH (W)
    ) u_step (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_next)
    );

    // Sign fix-up on the finished magnitudes; divide-by-zero forces LO to all
    // ones while the remainder path already reproduces the original dividend.
    always_comb begin
        w_prod     = r_neg_lo ? -r_acc : r_acc;
        w_quo      = r_neg_lo ? -r_acc[W-1:0] : r_acc[W-1:0];
        w_rem      = r_neg_hi ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
        w_div_zero = md_is_div(r_op) && (r_opnd == '0);
        if (md_is_div(r_op)) begin
            w_hi_res = w_rem;
            w_lo_res = w_div_zero ? '1 : w_quo;
        end else begin
            w_hi_res = w_prod[2*W-1:W];
            w_lo_res = w_prod[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= MD_IDLE;
            r_op       <= MD_MULT;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_count    <= '0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                MD_IDLE: begin
                    if (start_i) begin
                        r_op       <= w_op_in;
                        r_state    <= MD_CALC;
                        r_busy     <= 1'b1;
                        r_count    <= '0;
                        r_div_zero <= 1'b0;
                        r_neg_lo   <= w_a_neg ^ w_b_neg;
                        r_neg_hi   <= w_is_div & w_a_neg;
                        if (w_is_div) begin
                            r_acc  <= {{W{1'b0}}, w_a_mag};
                            r_opnd <= w_b_mag;
                        end else begin
                            r_acc  <= {{W{1'b0}}, w_b_mag};
                            r_opnd <= w_a_mag;
                        end
                    end else begin
                        if (mthi_i) r_hi <= a_i;
                        if (mtlo_i) r_lo <= a_i;
                    end
                end
                MD_CALC: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST) r_state <= MD_SIGN;
                end
                MD_SIGN: begin
                    r_hi       <= w_hi_res;
                    r_lo       <= w_lo_res;
                    r_div_zero <= w_div_zero;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= MD_IDLE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign div_zero_o = r_div_zero;
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS core. Extends the ISA with mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Sits beside the ALU stage. Operands come from the register-file read ports (rs on a, rt on b).
- HI/LO feed the write-back mux for mfhi/mflo.
- The control unit holds the PC stalled while busy_o is high.

Parameters:
- DATA_WIDTH, 32: operand, HI and LO width. The iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start_i  input  1  single-cycle request; sampled only in IDLE.
- op_i  input  2  operation, sampled with start_i: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a_i  input  DATA_WIDTH  rs value, multiplicand or dividend.
- b_i  input  DATA_WIDTH  rt value, multiplier or divisor.
- mthi_i  input  1  write a_i into HI (IDLE only).
- mtlo_i  input  1  write a_i into LO (IDLE only).
- busy_o  output  1  operation in progress; the core stalls on it.
- done_o  output  1  one-cycle pulse when HI/LO receive a new result.
- div_zero_o  output  1  sticky flag: the last div/divu had b=0; cleared by the next start.
- hi_o  output  DATA_WIDTH  HI register.
- lo_o  output  DATA_WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE; hi_o, lo_o, count and working registers all 0; busy_o, done_o and div_zero_o all 0.
- Reset mid-operation: aborts at once; HI/LO return to 0; no done_o pulse.
- State machine: IDLE, CALC, SIGN.
  - IDLE, start_i=1 at edge k: latch op and operand magnitudes, record result signs, set count=0, go to CALC. Signed ops take absolute values; unsigned ops pass operands through.
  - CALC: one iteration per edge, edges k+1 through k+DATA_WIDTH. Leaves for SIGN when count reaches DATA_WIDTH-1.
  - SIGN, edge k+DATA_WIDTH+1: apply sign correction, write HI/LO, drive done_o=1 for the following cycle, go to IDLE.
- Timing:
  - busy_o = (state != IDLE), registered. It is high for DATA_WIDTH+1 cycles after edge k.
  - Total latency from start_i to HI/LO update is DATA_WIDTH+2 edges (34 for the default).
- Multiply: shift-add over a 2*DATA_WIDTH accumulator. HI = upper half, LO = lower half. MULT negates the 64-bit product when the operand signs differ.
- Divide: restoring algorithm, one quotient bit per iteration. LO = quotient, HI = remainder. DIV truncates toward zero:
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of the dividend.
- Divide-by-zero: no iteration shortcut; the full latency still applies. Result is LO = all ones, HI = dividend (a_i as sampled), and div_zero_o is set.
- Overflow case (-2^31 / -1): LO = 0x80000000, HI = 0. No trap.
- Request and write rules:
  - start_i while busy: ignored, no queueing. Operands are captured at start, so later a_i/b_i changes have no effect.
  - mthi_i/mtlo_i while busy: ignored.
  - mthi_i/mtlo_i in IDLE: update HI/LO at the next edge, with no done_o pulse.
  - start_i together with mthi_i/mtlo_i in IDLE: start wins and the move is dropped.
  - mthi_i and mtlo_i together: both registers take a_i.
- hi_o/lo_o hold their previous values throughout CALC. The new result appears only on the SIGN edge.

Decomposition:
- Shared package (mips_pkg):
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - state encodings MD_IDLE, MD_CALC, MD_SIGN;
  - the funct codes for mult/multu/div/divu/mfhi/mflo/mthi/mtlo, for use by ALU_Control.
- Sub-module: md_datapath_step, combinational. It performs one shift-add or restore-subtract step and is selected by op. The top level holds the FSM, counter, sign fix-up and HI/LO registers.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done_o 34 edges after start; HI=0xFFFFFFFE, LO=0x00000001; busy_o high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU a=7, b=2 -> LO=3, HI=1.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, div_zero_o=1. Next start clears div_zero_o.
- Start MULT 6*7, then assert start_i (DIV) and mthi_i during the busy window -> both ignored; final HI=0, LO=42. In IDLE: mtlo_i with a=0xA5A5A5A5 -> LO=0xA5A5A5A5, done_o stays 0.
- Assert reset at cycle 10 of a DIV -> busy_o, HI and LO drop to 0 asynchronously with no done_o. A new start after reset release completes normally.
